otp_byte_packer: RTL and testbench
==================================

Name: otp_byte_packer

Overview:
- Receive-side counterpart of the word-to-byte serializer on the one-time-pad datapath.
- Accepts a stream of bytes, most significant byte first, each tagged valid and with an optional last marker.
- Reassembles each group of NBYTES bytes into one word and presents it to the downstream pad/XOR stage with a valid/ready handshake.
- Keeps one assembled word buffered so byte intake continues while the previous word waits for downstream.

Parameters:
- NBYTES, 4: bytes per word; legal values 2..8.
- WIDTH, 8*NBYTES: output word width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- byte_in  input  8  byte data; don't-care when byte_valid=0.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_last  input  1  marks the final byte of a word; qualified by byte_valid.
- byte_ready  output  1  packer can accept a byte this cycle (combinational).
- word_out  output  WIDTH  assembled word; byte 0 is in [WIDTH-1:WIDTH-8].
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  downstream accepts word_out this cycle.
- frame_err  output  1  one-cycle pulse on a framing violation.
- busy  output  1  partial word in progress (cnt != 0).

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - acc=0, cnt=0, word_out=0, word_valid=0, frame_err=0, busy=0.
  - byte_ready=1 in the first cycle after reset.
- Byte accept: byte_valid && byte_ready.
  - On accept, acc <= {acc[WIDTH-9:0], byte_in} and cnt increments.
- Word completion: a byte accepted with cnt==NBYTES-1 completes the word.
  - word_out <= {acc[WIDTH-9:0], byte_in}, word_valid <= 1, cnt <= 0.
  - Latency: word_valid rises the cycle after the final byte is accepted.
- Word consume: word_valid && word_ready clears word_valid next cycle.
  - word_out holds its value after consume.
- byte_ready = (cnt != NBYTES-1) || !word_valid || word_ready.
  - Only the completing byte can stall.
  - Non-completing bytes are always accepted.
- Simultaneous consume and complete in one cycle: the new word loads, word_valid stays 1, and no cycle is lost.
- Sustained throughput: one byte per clock when word_ready is held high.
- word_out and word_valid must not change while word_valid=1 && word_ready=0.
- byte_in and byte_last are ignored when byte_valid=0, and also when byte_ready=0.
- Reset mid-word: the partial word is discarded, and the next accepted byte is byte 0.
- Reset while word_valid=1: the buffered word is dropped.
- busy = (cnt != 0), registered state.

Optional Feature:
- Macro: OTP_FRAME_CHECK_EN.
- Defined:
  - An accepted byte with byte_last=1 and cnt != NBYTES-1 raises frame_err for one cycle, discards the partial word (cnt<=0, acc<=0), and produces no word.
  - An accepted completing byte with byte_last=0 raises frame_err for one cycle. The word is still emitted normally.
- Undefined:
  - byte_last is ignored; framing is purely count-based.
  - frame_err is tied to 0.

Test Plan:
- After reset, send DE, AD, BE, EF on consecutive cycles with word_ready=1 -> word_valid high one cycle after the EF accept, word_out=32'hDEADBEEF, busy high for 3 cycles.
- Hold word_ready=0 and send 11 22 33 44 55 66 77 88 back-to-back -> first word 32'h11223344 held stable; bytes 55, 66, 77 accepted; byte_ready=0 while 88 is presented. Then raise word_ready -> 88 accepted that same cycle and word_out becomes 32'h55667788 with no gap.
- Stream 3 words back-to-back with word_ready=1 -> a word_valid pulse every 4 cycles, words in MSB-first order, no dropped bytes.
- Send AA, BB, then assert reset for one cycle, then send 01 02 03 04 -> word_out=32'h01020304, no word containing AA or BB.
- With OTP_FRAME_CHECK_EN defined, send C0, C1 with byte_last=1 on C1 -> frame_err pulses 1 cycle, no word_valid. Next 4 bytes with last on the 4th -> one correct word, frame_err=0.
- With OTP_FRAME_CHECK_EN undefined, repeat the previous stimulus -> frame_err stays 0, and C0 C1 plus the next two bytes form one word.

Source files
------------

// File: rtl/otp_byte_packer.sv
// Byte-to-word packer for the OTP receive path: MSB-first bytes in, one buffered word out.
// Optional framing check on byte_last is enabled by defining OTP_FRAME_CHECK_EN.
module otp_byte_packer #(
    parameter int NBYTES = 4,
    parameter int WIDTH  = 8*NBYTES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             byte_last,
    output logic             byte_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             frame_err,
    output logic             busy
);

    localparam int            CW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int            AW       = WIDTH - 8;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    // Only NBYTES-1 bytes need holding; the completing byte goes straight into the word.
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_word_valid;
    logic             r_frame_err;
    logic             r_busy;

    logic             w_last_slot;
    logic             w_accept;
    logic             w_consume;
    logic             w_drop;
    logic             w_bad_end;
    logic [WIDTH-1:0] w_shift;
    logic [CW-1:0]    w_cnt_nxt;
    logic [AW-1:0]    w_acc_nxt;

    assign w_last_slot = (r_cnt == LAST_IDX);
    assign byte_ready  = !w_last_slot || !r_word_valid || word_ready;
    assign w_accept    = byte_valid && byte_ready;
    assign w_consume   = r_word_valid && word_ready;
    assign w_shift     = {r_acc, byte_in};

`ifdef OTP_FRAME_CHECK_EN
    assign w_drop    = w_accept && byte_last && !w_last_slot;
    assign w_bad_end = w_accept && !byte_last && w_last_slot;
`else
    logic w_unused_last;
    assign w_unused_last = byte_last;
    assign w_drop        = 1'b0;
    assign w_bad_end     = 1'b0;
`endif

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_acc_nxt = r_acc;
        if (w_drop) begin
            w_cnt_nxt = '0;
            w_acc_nxt = '0;
        end else if (w_accept) begin
            w_acc_nxt = w_shift[AW-1:0];
            w_cnt_nxt = w_last_slot ? '0 : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_cnt_nxt != '0);
            r_frame_err <= w_drop || w_bad_end;
            // A completing byte may load while the old word is consumed in the same cycle.
            if (w_accept && w_last_slot) begin
                r_word       <= w_shift;
                r_word_valid <= 1'b1;
            end else if (w_consume) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_word_valid;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_otp_byte_packer.sv
// Self-checking bench for otp_byte_packer: directed steps plus random traffic against a queue model.
// Expectations follow OTP_FRAME_CHECK_EN when it is defined for the build.
module tb_otp_byte_packer;

    localparam int NB = 4;
    localparam int W  = 8*NB;

    logic         clk;
    logic         reset;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_last;
    logic         byte_ready;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_ready;
    logic         frame_err;
    logic         busy;

    otp_byte_packer #(.NBYTES(NB)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes of the word in progress, plus the single output buffer.
    logic [7:0]   q[$];
    logic [W-1:0] m_word;
    bit           m_valid;
    bit           m_err;
    bit           seen_rdy;
    int           dut_words;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit l, input bit wr);
        bit           exp_rdy;
        bit           acc;
        logic [W-1:0] w;
        @(negedge clk);
        byte_valid = v;
        byte_in    = b;
        byte_last  = l;
        word_ready = wr;
        #1;
        exp_rdy  = (q.size() != NB-1) || !m_valid || wr;
        seen_rdy = byte_ready;
        chk("byte_ready", byte_ready, exp_rdy);
        acc   = v && exp_rdy;
        m_err = 1'b0;
        if (m_valid && wr) m_valid = 1'b0;
        if (acc) begin
`ifdef OTP_FRAME_CHECK_EN
            if (l && q.size() != NB-1) begin
                q.delete();
                m_err = 1'b1;
            end else begin
                q.push_back(b);
                if (q.size() == NB && !l) m_err = 1'b1;
            end
`else
            q.push_back(b);
`endif
            if (q.size() == NB) begin
                w = '0;
                foreach (q[i]) w = (w << 8) | W'(q[i]);
                m_word  = w;
                m_valid = 1'b1;
                q.delete();
            end
        end
        @(posedge clk);
        #1;
        if (word_valid === 1'b1) dut_words++;
        chk("word_valid", word_valid, m_valid);
        chk("word_out", word_out, m_word);
        chk("frame_err", frame_err, m_err);
        chk("busy", busy, q.size() != 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b0;
        word_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_valid = 1'b0;
        m_word  = '0;
        m_err   = 1'b0;
        chk("rst_word_valid", word_valid, 1'b0);
        chk("rst_word_out", word_out, '0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_byte_ready", byte_ready, 1'b1);
    endtask

    initial begin
        int d0;
        bit rl;
        reset      = 1'b1;
        byte_in    = '0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        word_ready = 1'b0;
        m_word     = '0;
        m_valid    = 1'b0;
        m_err      = 1'b0;
        dut_words  = 0;
        do_reset();

        // First word straight through.
        step(1, 8'hDE, 0, 1);
        step(1, 8'hAD, 0, 1);
        step(1, 8'hBE, 0, 1);
        step(1, 8'hEF, 1, 1);
        chk("deadbeef", word_out, 32'hDEADBEEF);
        step(0, 8'h00, 0, 1);

        // Downstream stalled: fourth byte of the second word must wait.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 1, 0);
        step(1, 8'h55, 0, 0);
        step(1, 8'h66, 0, 0);
        step(1, 8'h77, 0, 0);
        step(1, 8'h88, 1, 0);
        chk("stall_ready", seen_rdy, 1'b0);
        step(1, 8'h88, 1, 0);
        chk("held_word", word_out, 32'h11223344);
        step(1, 8'h88, 1, 1);
        chk("swap_ready", seen_rdy, 1'b1);
        chk("swap_word", word_out, 32'h55667788);
        step(0, 8'h00, 0, 1);

        // Three words back to back at one byte per clock.
        d0 = dut_words;
        for (int k = 0; k < 12; k++) step(1, 8'hA0 + 8'(k), (k % 4) == 3, 1);
        chk("stream_words", dut_words - d0, 3);
        chk("stream_last", word_out, 32'hA8A9AAAB);
        step(0, 8'h00, 0, 1);

        // Reset mid-word discards the partial bytes.
        step(1, 8'hAA, 0, 1);
        step(1, 8'hBB, 0, 1);
        do_reset();
        step(1, 8'h01, 0, 1);
        step(1, 8'h02, 0, 1);
        step(1, 8'h03, 0, 1);
        step(1, 8'h04, 1, 1);
        chk("post_reset_word", word_out, 32'h01020304);

        // Early byte_last.
        do_reset();
        step(1, 8'hC0, 0, 1);
        step(1, 8'hC1, 1, 1);
`ifdef OTP_FRAME_CHECK_EN
        chk("early_last_err", frame_err, 1'b1);
        chk("early_last_nowd", word_valid, 1'b0);
        step(1, 8'h10, 0, 1);
        step(1, 8'h20, 0, 1);
        step(1, 8'h30, 0, 1);
        step(1, 8'h40, 1, 1);
        chk("reframed_word", word_out, 32'h10203040);
        chk("reframed_err", frame_err, 1'b0);
`else
        chk("early_last_noerr", frame_err, 1'b0);
        step(1, 8'h10, 0, 1);
        step(1, 8'h20, 0, 1);
        chk("countframe_word", word_out, 32'hC0C11020);
        step(1, 8'h30, 0, 1);
        step(1, 8'h40, 1, 1);
`endif

        // Random traffic with occasional resets and framing slips.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
`ifdef OTP_FRAME_CHECK_EN
            rl = (q.size() == NB-1) ^ ($urandom_range(0, 15) == 0);
`else
            rl = 1'($urandom);
`endif
            step($urandom_range(0, 9) < 7, 8'($urandom), rl, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
